// File: rtl/mat_mult_pkg.sv
// Shared defaults, FSM state type and packed-stream indexing helpers for mat_mult_seq.
package mat_mult_pkg;

  localparam int MM_N      = 3;
  localparam int MM_DATA_W = 16;
  localparam int MM_ACC_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int elem_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

  // Element (0,0) sits in the MSBs of a packed stream.
  function automatic int elem_lsb(input int r, input int c, input int n, input int w);
    return (n * n - 1 - elem_idx(r, c, n)) * w;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-accumulate: acc_next_o = acc_i + a_i*b_i, wrapping at ACC_W bits.
// Two's-complement operands when MAT_MULT_SEQ_SIGNED_EN is defined, unsigned otherwise.
module mac_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ACC_W-1:0]  acc_i,
  output logic [ACC_W-1:0]  acc_next_o
);

  logic [2*DATA_W-1:0] a_x;
  logic [2*DATA_W-1:0] b_x;
  logic [2*DATA_W-1:0] prod;

`ifdef MAT_MULT_SEQ_SIGNED_EN
  // Low 2*DATA_W bits of the product of sign-extended operands equal the signed product.
  assign a_x        = {{DATA_W{a_i[DATA_W-1]}}, a_i};
  assign b_x        = {{DATA_W{b_i[DATA_W-1]}}, b_i};
  assign prod       = a_x * b_x;
  assign acc_next_o = acc_i + ACC_W'($signed(prod));
`else
  assign a_x        = {{DATA_W{1'b0}}, a_i};
  assign b_x        = {{DATA_W{1'b0}}, b_i};
  assign prod       = a_x * b_x;
  assign acc_next_o = acc_i + ACC_W'(prod);
`endif

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential NxN matrix multiplier: one shared MAC, N^3 cycles per job, result held until accepted.
// Optional MAT_MULT_SEQ_SIGNED_EN selects two's-complement arithmetic in the MAC.
module mat_mult_seq
  import mat_mult_pkg::*;
#(
  parameter int N      = MM_N,
  parameter int DATA_W = MM_DATA_W,
  parameter int ACC_W  = MM_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*N*DATA_W-1:0]   matrix_a_stream,
  input  logic [N*N*DATA_W-1:0]   matrix_b_stream,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*N*ACC_W-1:0]    matrix_c_stream,
  output logic                    busy
);

  localparam int NN = N * N;
  localparam int IW = $clog2(N);

  state_t                state_q, state_d;
  logic [NN*DATA_W-1:0]  a_q, a_d;
  logic [NN*DATA_W-1:0]  b_q, b_d;
  logic [NN*ACC_W-1:0]   c_q, c_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [IW-1:0]         i_q, i_d;
  logic [IW-1:0]         j_q, j_d;
  logic [IW-1:0]         k_q, k_d;

  logic [DATA_W-1:0]     a_el;
  logic [DATA_W-1:0]     b_el;
  logic [ACC_W-1:0]      acc_next;
  logic                  last_i, last_j, last_k;

  assign a_el = a_q[elem_lsb(int'(i_q), int'(k_q), N, DATA_W) +: DATA_W];
  assign b_el = b_q[elem_lsb(int'(k_q), int'(j_q), N, DATA_W) +: DATA_W];

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a_i        (a_el),
    .b_i        (b_el),
    .acc_i      (acc_q),
    .acc_next_o (acc_next)
  );

  assign last_i = (i_q == IW'(N - 1));
  assign last_j = (j_q == IW'(N - 1));
  assign last_k = (k_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;

    if (abort) begin
      // C keeps whatever was written so far; only the job state is dropped.
      state_d = IDLE;
      acc_d   = '0;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d     = matrix_a_stream;
            b_d     = matrix_b_stream;
            acc_d   = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = MAC;
          end
        end
        MAC: begin
          if (!last_k) begin
            acc_d = acc_next;
            k_d   = k_q + 1'b1;
          end else begin
            c_d[elem_lsb(int'(i_q), int'(j_q), N, ACC_W) +: ACC_W] = acc_next;
            acc_d = '0;
            k_d   = '0;
            if (last_j) begin
              j_d = '0;
              if (last_i) begin
                i_d     = '0;
                state_d = DONE;
              end else begin
                i_d = i_q + 1'b1;
              end
            end else begin
              j_d = j_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q == DONE);
  assign busy            = (state_q != IDLE);
  assign matrix_c_stream = c_q;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Randomized bench for mat_mult_seq with a matrix-level reference model and per-cycle output checks.
module tb_mat_mult_seq;

  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int AW  = 32;
  localparam int NN  = N * N;
  localparam int LAT = N * N * N;
  localparam int CW  = NN * AW;

  logic          clk;
  logic          rst;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [NN*DW-1:0] a_s;
  logic [NN*DW-1:0] b_s;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] c_s;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  mat_mult_seq #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .abort           (abort),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .matrix_a_stream (a_s),
    .matrix_b_stream (b_s),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .matrix_c_stream (c_s),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NN*DW-1:0] pack(input int unsigned m[NN]);
    logic [NN*DW-1:0] r;
    r = '0;
    for (int e = 0; e < NN; e++) r[(NN-1-e)*DW +: DW] = m[e][DW-1:0];
    return r;
  endfunction

  function automatic logic [AW-1:0] elem_c(input logic [CW-1:0] s, input int e);
    return s[(NN-1-e)*AW +: AW];
  endfunction

  // Reference product: plain triple loop with 64-bit products truncated to AW.
  function automatic logic [CW-1:0] matmul(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b);
    logic [CW-1:0] res;
    logic [AW-1:0] acc;
    logic [DW-1:0] x, y;
    logic [63:0]   p;
    res = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
          x = a[(NN-1-(r*N+k))*DW +: DW];
          y = b[(NN-1-(k*N+c))*DW +: DW];
`ifdef MAT_MULT_SEQ_SIGNED_EN
          p = 64'($signed(x)) * 64'($signed(y));
`else
          p = 64'(x) * 64'(y);
`endif
          acc = acc + p[AW-1:0];
        end
        res[(NN-1-(r*N+c))*AW +: AW] = acc;
      end
    end
    return res;
  endfunction

  // Job-level model: 0 = idle, 1 = computing (cycles left in cnt), 2 = result offered.
  int            mode = 0;
  int            cnt = 0;
  bit            live = 1'b0;
  bit            c_known = 1'b0;
  logic [CW-1:0] c_exp = '0;
  logic [CW-1:0] c_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      live    <= 1'b1;
      mode    <= 0;
      cnt     <= 0;
      c_known <= 1'b1;
      c_exp   <= '0;
    end else if (live) begin
      if (abort) begin
        if (mode == 1) c_known <= 1'b0;
        mode <= 0;
      end else begin
        case (mode)
          0: if (in_valid) begin
               c_pend  <= matmul(a_s, b_s);
               mode    <= 1;
               cnt     <= LAT;
               c_known <= 1'b0;
             end
          1: begin
               cnt <= cnt - 1;
               if (cnt == 1) begin
                 mode    <= 2;
                 c_exp   <= c_pend;
                 c_known <= 1'b1;
               end
             end
          2: if (out_ready) mode <= 0;
          default: mode <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk_b("in_ready", in_ready, mode == 0);
      chk_b("out_valid", out_valid, mode == 2);
      chk_b("busy", busy, mode != 0);
      if (c_known) chk_w("c_stream", c_s, c_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b);
    a_s      = a;
    b_s      = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid) chk_b("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic release_out(input int hold);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_c_lit(input string tag, input int unsigned lit[NN]);
    for (int e = 0; e < NN; e++)
      chk_w($sformatf("%s[%0d]", tag, e), CW'(elem_c(c_s, e)), CW'(lit[e]));
  endtask

  int unsigned seq1[NN]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int unsigned seq10[NN] = '{10, 11, 12, 13, 14, 15, 16, 17, 18};
  int unsigned ident[NN] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int unsigned two_i[NN] = '{2, 0, 0, 0, 2, 0, 0, 0, 2};
  int unsigned c1[NN]    = '{84, 90, 96, 201, 216, 231, 318, 342, 366};
  int unsigned c2[NN]    = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
  int unsigned ones[NN]  = '{default: 32'hFFFF};
`ifdef MAT_MULT_SEQ_SIGNED_EN
  int unsigned cff[NN]   = '{default: 32'd3};
`else
  int unsigned cff[NN]   = '{default: 32'hFFFA0003};
`endif

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin : driver
    int lat;
    int unsigned ra[NN];
    int unsigned rb[NN];

    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_s = '0; b_s = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_w("rst_c", c_s, '0);

    // Basic job, latency, then a long stall in DONE with a competing request.
    start_job(pack(seq1), pack(seq10));
    wait_out(lat);
    chk_i("latency1", lat, LAT);
    chk_c_lit("c1", c1);
    a_s = pack(seq10); b_s = pack(seq1); in_valid = 1'b1;
    repeat (10) tick();
    chk_b("stall_out_valid", out_valid, 1'b1);
    chk_b("stall_in_ready", in_ready, 1'b0);
    chk_c_lit("c1_held", c1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_b("post_accept_in_ready", in_ready, 1'b1);

    // Back-to-back: identity B, then 2I x {1..9}.
    for (int e = 0; e < NN; e++) ra[e] = $urandom_range(0, 16'hFFFF);
    start_job(pack(ra), pack(ident));
    wait_out(lat);
    chk_i("latency2", lat, LAT);
    for (int e = 0; e < NN; e++)
      chk_w($sformatf("c_ident[%0d]", e), CW'(elem_c(c_s, e)), CW'(ra[e]));
    release_out(0);
    start_job(pack(two_i), pack(seq1));
    wait_out(lat);
    chk_c_lit("c2", c2);
    release_out(2);

    // All-ones operands.
    start_job(pack(ones), pack(ones));
    wait_out(lat);
    chk_c_lit("cff", cff);
    release_out(1);

    // Abort ten cycles into MAC; no result may ever be offered.
    start_job(pack(seq10), pack(seq10));
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_b("abort_in_ready", in_ready, 1'b1);
    repeat (40) tick();
    start_job(pack(seq1), pack(seq10));
    wait_out(lat);
    chk_i("latency_after_abort", lat, LAT);
    chk_c_lit("c1_after_abort", c1);
    release_out(0);

    // Reset in the middle of a job.
    for (int e = 0; e < NN; e++) ra[e] = $urandom_range(0, 16'hFFFF);
    start_job(pack(ra), pack(seq10));
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_b("mid_rst_in_ready", in_ready, 1'b1);
    chk_b("mid_rst_out_valid", out_valid, 1'b0);
    chk_b("mid_rst_busy", busy, 1'b0);
    chk_w("mid_rst_c", c_s, '0);
    start_job(pack(seq1), pack(seq10));
    wait_out(lat);
    chk_c_lit("c1_after_rst", c1);
    release_out(0);

    // Random jobs with random consumer stalls and idle gaps.
    for (int t = 0; t < 12; t++) begin
      for (int e = 0; e < NN; e++) begin
        ra[e] = $urandom_range(0, 16'hFFFF);
        rb[e] = $urandom_range(0, 16'hFFFF);
      end
      repeat ($urandom_range(0, 3)) tick();
      start_job(pack(ra), pack(rb));
      wait_out(lat);
      chk_i($sformatf("latency_rand%0d", t), lat, LAT);
      release_out($urandom_range(0, 4));
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
